game_flow_ctrl: RTL and testbench

- Parametrised successor to the top-level game-flow controller: WELCOME (team-name entry) -> START (map preview countdown) -> PLAY -> PAUSE -> FINISH.
- Adds configurable name length, start delay and pause mode, on-chip button edge detection, a visible start countdown, forfeit from pause, a lockout in FINISH, and a session high score.
- Sits beside the time_remaining and orders_and_points instances. It drives their timer_go and restart_timer and reads back time_left and point_total.

---
 rtl/game_pkg.sv | 41 ++++
 rtl/button_edge.sv | 30 +++
 rtl/game_flow_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding, letter constants, button indices.
package game_pkg;

   typedef enum logic [2:0] {
      WELCOME = 3'd0,
      START   = 3'd1,
      PLAY    = 3'd2,
      PAUSE   = 3'd3,
      FINISH  = 3'd4
   } game_state_e;

   localparam logic [7:0] ASCII_A = 8'h41;
   localparam logic [7:0] ASCII_Z = 8'h5A;

   // Bit positions of the player buttons on the edge-detector bus.
   localparam int unsigned NUM_BTN   = 7;
   localparam int unsigned BTN_LEFT  = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_UP    = 2;
   localparam int unsigned BTN_DOWN  = 3;
   localparam int unsigned BTN_CHOP  = 4;
   localparam int unsigned BTN_CARRY = 5;
   localparam int unsigned BTN_PAUSE = 6;

   // Previous letter, 'A' wraps to 'Z'; anything outside A..Z also lands on 'Z'.
   function automatic logic [7:0] letter_prev(input logic [7:0] c);
      if ((c <= ASCII_A) || (c > ASCII_Z)) begin
         return ASCII_Z;
      end
      return c - 8'd1;
   endfunction

   // Next letter, 'Z' wraps to 'A'; anything outside A..Z also lands on 'A'.
   function automatic logic [7:0] letter_next(input logic [7:0] c);
      if ((c >= ASCII_Z) || (c < ASCII_A)) begin
         return ASCII_A;
      end
      return c + 8'd1;
   endfunction

endpackage

// File: rtl/button_edge.sv
// Per-frame rising-edge detector for a bus of button levels.
module button_edge #(
   parameter int unsigned N = 7
) (
   input  logic         vsync,
   input  logic         reset,
   input  logic [N-1:0] level,
   output logic [N-1:0] rise
);

   logic [N-1:0] prev_q;
   logic [N-1:0] prev_d;

   // Next history is simply this frame's sample.
   always_comb begin
      prev_d = level;
   end

   // History updates every frame regardless of game state.
   always_ff @(negedge vsync) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow controller: name entry, start countdown, play/pause, finish lockout
// and session high score. All state advances on the falling edge of vsync.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned NAME_LEN       = 3,
   parameter int unsigned FRAMES_PER_SEC = 60,
   parameter int unsigned START_SECS     = 5,
   parameter int unsigned FINISH_LOCK    = 60,
   parameter int unsigned PAUSE_MODE     = 0
) (
   input  logic                       vsync,
   input  logic                       reset,
   input  logic                       pause,
   input  logic                       left,
   input  logic                       right,
   input  logic                       up,
   input  logic                       down,
   input  logic                       chop,
   input  logic                       carry,
   input  logic [7:0]                 time_left,
   input  logic [9:0]                 point_total,
   output logic [2:0]                 game_state,
   output logic [NAME_LEN*8-1:0]      team_name,
   output logic [$clog2(NAME_LEN):0]  cursor,
   output logic [3:0]                 start_secs_left,
   output logic                       timer_go,
   output logic                       restart_timer,
   output logic [9:0]                 high_score,
   output logic                       new_record
);

   localparam int unsigned CW  = $clog2(NAME_LEN) + 1;
   localparam int unsigned FCW = $clog2(FRAMES_PER_SEC) + 1;
   localparam int unsigned LCW = $clog2(FINISH_LOCK + 1) + 1;

   localparam logic [CW-1:0]  CURSOR_LAST = CW'(NAME_LEN - 1);
   localparam logic [FCW-1:0] FRAME_LAST  = FCW'(FRAMES_PER_SEC - 1);
   localparam logic [LCW-1:0] LOCK_FRAMES = LCW'(FINISH_LOCK);
   localparam logic [3:0]     START_LOAD  = 4'(START_SECS);

   game_state_e             state_q, state_d;
   logic [NAME_LEN*8-1:0]   team_name_q, team_name_d;
   logic [CW-1:0]           cursor_q, cursor_d;
   logic [3:0]              secs_q, secs_d;
   logic                    timer_go_q, timer_go_d;
   logic                    restart_q, restart_d;
   logic [9:0]              high_score_q, high_score_d;
   logic                    new_record_q, new_record_d;
   logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;
   logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;

   logic [NUM_BTN-1:0]      btn_level;
   logic [NUM_BTN-1:0]      btn_rise;
   logic                    pause_req;
   logic                    resume_req;
   logic                    any_nav_rise;
   logic                    enter_start;
   logic                    enter_finish;
   int unsigned             sel_slot;

   assign btn_level[BTN_LEFT]  = left;
   assign btn_level[BTN_RIGHT] = right;
   assign btn_level[BTN_UP]    = up;
   assign btn_level[BTN_DOWN]  = down;
   assign btn_level[BTN_CHOP]  = chop;
   assign btn_level[BTN_CARRY] = carry;
   assign btn_level[BTN_PAUSE] = pause;

   button_edge #(
      .N (NUM_BTN)
   ) u_button_edge (
      .vsync (vsync),
      .reset (reset),
      .level (btn_level),
      .rise  (btn_rise)
   );

   // Pause/resume qualification depends on whether pause is held or toggled.
   always_comb begin
      if (PAUSE_MODE == 1) begin
         pause_req  = btn_rise[BTN_PAUSE];
         resume_req = btn_rise[BTN_PAUSE];
      end else begin
         pause_req  = pause;
         resume_req = ~pause;
      end
      any_nav_rise = btn_rise[BTN_LEFT] | btn_rise[BTN_RIGHT] | btn_rise[BTN_UP] |
                     btn_rise[BTN_DOWN] | btn_rise[BTN_CHOP];
   end

   // Next-state and next-output computation for the whole game flow.
   always_comb begin
      state_d      = state_q;
      team_name_d  = team_name_q;
      cursor_d     = cursor_q;
      secs_d       = secs_q;
      timer_go_d   = timer_go_q;
      restart_d    = restart_q;
      high_score_d = high_score_q;
      new_record_d = new_record_q;
      frame_cnt_d  = frame_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      enter_start  = 1'b0;
      enter_finish = 1'b0;
      // Slot NAME_LEN-1 is the leftmost letter, which is cursor position 0.
      sel_slot     = NAME_LEN - 1 - 32'(cursor_q);

      case (state_q)
         WELCOME: begin
            if (btn_rise[BTN_CHOP]) begin
               enter_start = 1'b1;
            end else if (btn_rise[BTN_UP]) begin
               for (int i = 0; i < int'(NAME_LEN); i++) begin
                  if (i == int'(sel_slot)) begin
                     team_name_d[i*8 +: 8] = letter_prev(team_name_q[i*8 +: 8]);
                  end
               end
            end else if (btn_rise[BTN_DOWN]) begin
               for (int i = 0; i < int'(NAME_LEN); i++) begin
                  if (i == int'(sel_slot)) begin
                     team_name_d[i*8 +: 8] = letter_next(team_name_q[i*8 +: 8]);
                  end
               end
            end else if (btn_rise[BTN_RIGHT]) begin
               if (cursor_q >= CURSOR_LAST) begin
                  enter_start = 1'b1;
               end else begin
                  cursor_d = cursor_q + 1'b1;
               end
            end else if (btn_rise[BTN_LEFT]) begin
               if (cursor_q != '0) begin
                  cursor_d = cursor_q - 1'b1;
               end
            end
         end

         START: begin
            if (frame_cnt_q >= FRAME_LAST) begin
               frame_cnt_d = '0;
               if (secs_q <= 4'd1) begin
                  state_d    = PLAY;
                  secs_d     = 4'd0;
                  restart_d  = 1'b0;
                  timer_go_d = 1'b1;
               end else begin
                  secs_d = secs_q - 4'd1;
               end
            end else begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end

         PLAY: begin
            if (time_left == 8'd0) begin
               enter_finish = 1'b1;
               timer_go_d   = 1'b0;
            end else if (pause_req) begin
               state_d    = PAUSE;
               timer_go_d = 1'b0;
            end
         end

         PAUSE: begin
            timer_go_d = 1'b0;
            // Forfeit wins over resume when both arrive in one frame.
            if (btn_rise[BTN_CARRY]) begin
               enter_finish = 1'b1;
            end else if (resume_req) begin
               state_d    = PLAY;
               timer_go_d = 1'b1;
            end
         end

         FINISH: begin
            if (lock_cnt_q < LOCK_FRAMES) begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end else if (any_nav_rise) begin
               state_d      = WELCOME;
               new_record_d = 1'b0;
               restart_d    = 1'b1;
            end
         end

         default: begin
            state_d = WELCOME;
         end
      endcase

      if (enter_start) begin
         state_d     = START;
         cursor_d    = '0;
         restart_d   = 1'b1;
         timer_go_d  = 1'b0;
         secs_d      = START_LOAD;
         frame_cnt_d = '0;
      end

      // Score is latched on the same edge the game ends, whichever way it ends.
      if (enter_finish) begin
         state_d    = FINISH;
         lock_cnt_d = '0;
         if (point_total > high_score_q) begin
            high_score_d = point_total;
            new_record_d = 1'b1;
         end else begin
            new_record_d = 1'b0;
         end
      end
   end

   // Register all state and outputs; reset restores the power-on picture.
   always_ff @(negedge vsync) begin
      if (reset) begin
         state_q      <= WELCOME;
         team_name_q  <= {NAME_LEN{ASCII_A}};
         cursor_q     <= '0;
         secs_q       <= START_LOAD;
         timer_go_q   <= 1'b0;
         restart_q    <= 1'b1;
         high_score_q <= '0;
         new_record_q <= 1'b0;
         frame_cnt_q  <= '0;
         lock_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         team_name_q  <= team_name_d;
         cursor_q     <= cursor_d;
         secs_q       <= secs_d;
         timer_go_q   <= timer_go_d;
         restart_q    <= restart_d;
         high_score_q <= high_score_d;
         new_record_q <= new_record_d;
         frame_cnt_q  <= frame_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   assign game_state      = state_q;
   assign team_name       = team_name_q;
   assign cursor          = cursor_q;
   assign start_secs_left = secs_q;
   assign timer_go        = timer_go_q;
   assign restart_timer   = restart_q;
   assign high_score      = high_score_q;
   assign new_record      = new_record_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with toggle-style pause.
module tb_game_flow_ctrl;

   logic        vsync;
   logic        reset;
   logic [6:0]  btn;   // {pause, carry, chop, down, up, right, left}
   logic [7:0]  time_left;
   logic [9:0]  point_total;
   logic [2:0]  game_state;
   logic [23:0] team_name;
   logic [2:0]  cursor;
   logic [3:0]  start_secs_left;
   logic        timer_go;
   logic        restart_timer;
   logic [9:0]  high_score;
   logic        new_record;

   int checks;
   int failures;

   localparam int L = 0, R = 1, U = 2, D = 3, C = 4, CA = 5, P = 6;
   localparam logic [31:0] S_WEL = 0, S_STA = 1, S_PLA = 2, S_PAU = 3, S_FIN = 4;

   game_flow_ctrl #(
      .NAME_LEN       (3),
      .FRAMES_PER_SEC (60),
      .START_SECS     (5),
      .FINISH_LOCK    (60),
      .PAUSE_MODE     (1)
   ) dut (
      .vsync           (vsync),
      .reset           (reset),
      .pause           (btn[P]),
      .left            (btn[L]),
      .right           (btn[R]),
      .up              (btn[U]),
      .down            (btn[D]),
      .chop            (btn[C]),
      .carry           (btn[CA]),
      .time_left       (time_left),
      .point_total     (point_total),
      .game_state      (game_state),
      .team_name       (team_name),
      .cursor          (cursor),
      .start_secs_left (start_secs_left),
      .timer_go        (timer_go),
      .restart_timer   (restart_timer),
      .high_score      (high_score),
      .new_record      (new_record)
   );

   initial vsync = 1'b0;
   always #5 vsync = ~vsync;

   task automatic tick();
      @(negedge vsync);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-frame press followed by one-frame release.
   task automatic press(input int b);
      btn[b] = 1'b1;
      tick();
      btn[b] = 1'b0;
      tick();
   endtask

   // Runs the 300-frame preview after the START entry edge.
   task automatic run_start(input string tag);
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 59)  chk({tag, "_secs59"}, 32'(start_secs_left), 5);
         if (i == 60)  chk({tag, "_secs60"}, 32'(start_secs_left), 4);
         if (i == 120) chk({tag, "_secs120"}, 32'(start_secs_left), 3);
         if (i == 180) chk({tag, "_secs180"}, 32'(start_secs_left), 2);
         if (i == 240) chk({tag, "_secs240"}, 32'(start_secs_left), 1);
         if (i == 299) chk({tag, "_still_start"}, 32'(game_state), S_STA);
         if (i == 300) begin
            chk({tag, "_play"}, 32'(game_state), S_PLA);
            chk({tag, "_timer_go"}, 32'(timer_go), 1);
            chk({tag, "_restart"}, 32'(restart_timer), 0);
         end
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      btn         = '0;
      time_left   = 8'd100;
      point_total = 10'd0;
      tick();
      tick();
      reset = 1'b0;

      // Reset picture
      chk("rst_state", 32'(game_state), S_WEL);
      chk("rst_name", 32'(team_name), 32'h414141);
      chk("rst_cursor", 32'(cursor), 0);
      chk("rst_secs", 32'(start_secs_left), 5);
      chk("rst_timer_go", 32'(timer_go), 0);
      chk("rst_restart", 32'(restart_timer), 1);
      chk("rst_high", 32'(high_score), 0);
      chk("rst_newrec", 32'(new_record), 0);

      // Down at cursor 0, then held: only one step
      btn[D] = 1'b1;
      tick();
      chk("down_once", 32'(team_name), 32'h424141);
      repeat (9) tick();
      chk("down_held", 32'(team_name), 32'h424141);
      btn[D] = 1'b0;
      tick();

      // Name entry: B->A->Z, right, A->Z, right, A->B
      press(U);
      chk("up_b_to_a", 32'(team_name), 32'h414141);
      press(U);
      chk("up_wrap_z", 32'(team_name), 32'h5A4141);
      press(L);
      chk("left_sat", 32'(cursor), 0);
      press(R);
      chk("right_c1", 32'(cursor), 1);
      press(U);
      press(R);
      press(D);
      chk("name_zzb", 32'(team_name), 32'h5A5A42);
      chk("cursor_2", 32'(cursor), 2);
      press(D);
      press(U);
      chk("slot0_only", 32'(team_name), 32'h5A5A42);

      // Right at last cursor enters START
      btn[R] = 1'b1;
      tick();
      btn[R] = 1'b0;
      chk("start_state", 32'(game_state), S_STA);
      chk("start_secs", 32'(start_secs_left), 5);
      chk("start_cursor", 32'(cursor), 0);
      chk("start_restart", 32'(restart_timer), 1);
      run_start("g1");

      // Toggle pause in and out, then pause and timeout together
      press(P);
      chk("pause_state", 32'(game_state), S_PAU);
      chk("pause_timer", 32'(timer_go), 0);
      press(P);
      chk("resume_state", 32'(game_state), S_PLA);
      chk("resume_timer", 32'(timer_go), 1);
      btn[P]      = 1'b1;
      time_left   = 8'd0;
      point_total = 10'd120;
      tick();
      btn[P] = 1'b0;
      chk("timeout_fin", 32'(game_state), S_FIN);
      chk("timeout_timer", 32'(timer_go), 0);
      chk("hs_120", 32'(high_score), 120);
      chk("newrec_1", 32'(new_record), 1);
      time_left = 8'd100;

      // FINISH lockout: chop at lock frame 30 and left at 59 ignored
      repeat (30) tick();
      btn[C] = 1'b1;
      tick();
      btn[C] = 1'b0;
      chk("lock_chop30", 32'(game_state), S_FIN);
      repeat (28) tick();
      btn[L] = 1'b1;
      tick();
      btn[L] = 1'b0;
      chk("lock_left59", 32'(game_state), S_FIN);
      tick();
      chk("lock_idle60", 32'(game_state), S_FIN);
      chk("lock_newrec", 32'(new_record), 1);
      btn[C] = 1'b1;
      tick();
      btn[C] = 1'b0;
      chk("unlock_wel", 32'(game_state), S_WEL);
      chk("unlock_name", 32'(team_name), 32'h5A5A42);
      chk("unlock_newrec", 32'(new_record), 0);
      chk("unlock_restart", 32'(restart_timer), 1);
      tick();

      // Second game ties the high score
      btn[C] = 1'b1;
      tick();
      btn[C] = 1'b0;
      chk("g2_start", 32'(game_state), S_STA);
      run_start("g2");
      tick();
      time_left = 8'd0;
      tick();
      chk("g2_fin", 32'(game_state), S_FIN);
      chk("g2_tie_newrec", 32'(new_record), 0);
      chk("g2_tie_hs", 32'(high_score), 120);
      time_left = 8'd100;

      // Third game: forfeit from PAUSE with a higher score
      repeat (61) tick();
      btn[U] = 1'b1;
      tick();
      btn[U] = 1'b0;
      chk("g3_wel", 32'(game_state), S_WEL);
      btn[C] = 1'b1;
      tick();
      btn[C] = 1'b0;
      run_start("g3");
      press(P);
      chk("g3_pause", 32'(game_state), S_PAU);
      point_total = 10'd200;
      btn[CA] = 1'b1;
      tick();
      btn[CA] = 1'b0;
      chk("forfeit_fin", 32'(game_state), S_FIN);
      chk("forfeit_hs", 32'(high_score), 200);
      chk("forfeit_newrec", 32'(new_record), 1);

      // Reset in the middle of START
      repeat (61) tick();
      btn[R] = 1'b1;
      tick();
      btn[R] = 1'b0;
      chk("g4_wel", 32'(game_state), S_WEL);
      btn[C] = 1'b1;
      tick();
      btn[C] = 1'b0;
      repeat (100) tick();
      chk("g4_secs", 32'(start_secs_left), 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_state", 32'(game_state), S_WEL);
      chk("mid_rst_name", 32'(team_name), 32'h414141);
      chk("mid_rst_secs", 32'(start_secs_left), 5);
      chk("mid_rst_restart", 32'(restart_timer), 1);
      chk("mid_rst_timer", 32'(timer_go), 0);
      chk("mid_rst_hs", 32'(high_score), 0);
      chk("mid_rst_newrec", 32'(new_record), 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
